// File: rtl/test_engine_nic_input_control_unit.sv
// ---------------------------------------------------------------------------
// test_engine_nic_input_control_unit
//
// Input-side sequencer of the test-engine NIC. Detects a header flit on the
// router input channel, steps the input register bank through one header slot
// plus DATA_FLITS data slots on consecutive cycles, then holds the packet until
// the PE is idle and the output block has credits, and issues a single-cycle
// start strobe to the PE.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a header flit; captures it into slot 0 on arrival
// CAPTURE | writing data flit `index` into slot `index`, one per cycle
// WAIT_PE | packet complete; waiting for PE idle and credits to strobe
//
// Ports
//   clk                      in   system clock, rising edge
//   reset                    in   asynchronous, active-high
//   header_field_din         in   channel bit 31, header flit present
//   busy_engine_din          in   PE busy
//   zero_credits_din         in   output block has no credits
//   transfer2pe_strobe_dout  out  one-cycle PE start pulse
//   write_strobe_dout        out  bank captures channel at next edge
//   register_enable_dout     out  one-hot slot select, bit0 = header slot
// ---------------------------------------------------------------------------
module test_engine_nic_input_control_unit #(
  parameter int DATA_FLITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  header_field_din,
  input  logic                  busy_engine_din,
  input  logic                  zero_credits_din,
  output logic                  transfer2pe_strobe_dout,
  output logic                  write_strobe_dout,
  output logic [DATA_FLITS:0]   register_enable_dout
);

  localparam int NUM_SLOTS = DATA_FLITS + 1;
  localparam int IDX_W     = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_FLITS);
  localparam logic [IDX_W-1:0]     FIRST_DATA_IDX = IDX_W'(1);
  localparam logic [NUM_SLOTS-1:0] SLOT0 = NUM_SLOTS'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WAIT_PE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] index, index_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
    end
  end

  always_comb begin
    state_next              = state;
    index_next              = index;
    write_strobe_dout       = 1'b0;
    register_enable_dout    = '0;
    transfer2pe_strobe_dout = 1'b0;

    case (state)
      IDLE: begin
        // Header slot is written in the same cycle the header is seen.
        if (header_field_din) begin
          write_strobe_dout    = 1'b1;
          register_enable_dout = SLOT0;
          state_next           = CAPTURE;
          index_next           = FIRST_DATA_IDX;
        end
      end

      CAPTURE: begin
        // Header bit is ignored here; flits arrive back to back.
        write_strobe_dout    = 1'b1;
        register_enable_dout = SLOT0 << index;
        if (index == LAST_IDX) begin
          state_next = WAIT_PE;
          index_next = '0;
        end else begin
          index_next = index + FIRST_DATA_IDX;
        end
      end

      WAIT_PE: begin
        transfer2pe_strobe_dout = ~busy_engine_din & ~zero_credits_din;
        if (transfer2pe_strobe_dout) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_test_engine_nic_input_control_unit.sv
module tb_test_engine_nic_input_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       header;
  logic       busy;
  logic       zc;
  logic       strobe;
  logic       ws;
  logic [4:0] re;

  int vectors     = 0;
  int miscompares = 0;
  int strobe_cnt  = 0;

  logic [6:0] exp_q[$];

  test_engine_nic_input_control_unit #(.DATA_FLITS(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .header_field_din        (header),
    .busy_engine_din         (busy),
    .zero_credits_din        (zc),
    .transfer2pe_strobe_dout (strobe),
    .write_strobe_dout       (ws),
    .register_enable_dout    (re)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (strobe === 1'b1) strobe_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare the oldest scoreboard entry against current outputs.
  task automatic compare(input string tag);
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_empty_q"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {25'd0, strobe, ws, re}, {25'd0, e});
    end
  endtask

  // One cycle: drive inputs, queue expected outputs, compare at negedge,
  // then advance past the rising edge.
  task automatic step(input string tag, input logic h, input logic b, input logic z,
                      input logic es, input logic ews, input logic [4:0] ere);
    header = h; busy = b; zc = z;
    exp_q.push_back({es, ews, ere});
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic clean_packet(input string tag);
    step({tag, "_c0"}, 1, 0, 0, 0, 1, 5'b00001);
    step({tag, "_c1"}, 0, 0, 0, 0, 1, 5'b00010);
    step({tag, "_c2"}, 0, 0, 0, 0, 1, 5'b00100);
    step({tag, "_c3"}, 0, 0, 0, 0, 1, 5'b01000);
    step({tag, "_c4"}, 0, 0, 0, 0, 1, 5'b10000);
    step({tag, "_c5"}, 0, 0, 0, 1, 0, 5'b00000);
    step({tag, "_c6"}, 0, 0, 0, 0, 0, 5'b00000);
  endtask

  initial begin
    reset = 1'b1; header = 0; busy = 0; zc = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: held in IDLE, outputs follow the IDLE rule.
    for (int i = 0; i < 10; i++) step("rst_idle", 0, 0, 0, 0, 0, 5'b00000);
    step("rst_hdr", 1, 0, 0, 0, 1, 5'b00001);
    step("rst_after", 0, 0, 0, 0, 0, 5'b00000);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("idle", 0, 1, 1, 0, 0, 5'b00000);

    // Basic packet, PE ready.
    clean_packet("pkt");

    // PE busy until cycle 8.
    step("busy_c0", 1, 1, 0, 0, 1, 5'b00001);
    step("busy_c1", 0, 1, 0, 0, 1, 5'b00010);
    step("busy_c2", 0, 1, 0, 0, 1, 5'b00100);
    step("busy_c3", 0, 1, 0, 0, 1, 5'b01000);
    step("busy_c4", 0, 1, 0, 0, 1, 5'b10000);
    step("busy_c5", 0, 1, 0, 0, 0, 5'b00000);
    step("busy_c6", 0, 1, 0, 0, 0, 5'b00000);
    step("busy_c7", 0, 1, 0, 0, 0, 5'b00000);
    step("busy_c8", 0, 0, 0, 1, 0, 5'b00000);
    step("busy_c9", 0, 0, 0, 0, 0, 5'b00000);

    // No credits after capture.
    step("zc_c0", 1, 0, 1, 0, 1, 5'b00001);
    step("zc_c1", 0, 0, 1, 0, 1, 5'b00010);
    step("zc_c2", 0, 0, 1, 0, 1, 5'b00100);
    step("zc_c3", 0, 0, 1, 0, 1, 5'b01000);
    step("zc_c4", 0, 0, 1, 0, 1, 5'b10000);
    for (int i = 0; i < 3; i++) step("zc_wait", 0, 0, 1, 0, 0, 5'b00000);
    step("zc_go", 0, 0, 0, 1, 0, 5'b00000);
    step("zc_idle", 0, 0, 0, 0, 0, 5'b00000);

    // Header held high through capture and wait: no restart, no extra strobe.
    step("hh_c0", 1, 1, 0, 0, 1, 5'b00001);
    step("hh_c1", 1, 1, 0, 0, 1, 5'b00010);
    step("hh_c2", 1, 1, 0, 0, 1, 5'b00100);
    step("hh_c3", 1, 1, 0, 0, 1, 5'b01000);
    step("hh_c4", 1, 1, 0, 0, 1, 5'b10000);
    step("hh_w0", 1, 1, 0, 0, 0, 5'b00000);
    step("hh_w1", 1, 1, 0, 0, 0, 5'b00000);
    step("hh_go", 1, 0, 0, 1, 0, 5'b00000);
    // Back in IDLE with header still high: next packet starts normally.
    step("hh2_c0", 1, 0, 0, 0, 1, 5'b00001);
    step("hh2_c1", 0, 0, 0, 0, 1, 5'b00010);
    step("hh2_c2", 0, 0, 0, 0, 1, 5'b00100);
    step("hh2_c3", 0, 0, 0, 0, 1, 5'b01000);
    step("hh2_c4", 0, 0, 0, 0, 1, 5'b10000);
    step("hh2_c5", 0, 0, 0, 1, 0, 5'b00000);
    step("hh2_c6", 0, 0, 0, 0, 0, 5'b00000);

    // Reset asserted at cycle 2 of a capture.
    step("mr_c0", 1, 0, 0, 0, 1, 5'b00001);
    step("mr_c1", 0, 0, 0, 0, 1, 5'b00010);
    header = 0;
    exp_q.push_back({1'b0, 1'b1, 5'b00100});
    @(negedge clk);
    compare("mr_c2");
    #1 reset = 1'b1;
    exp_q.push_back(7'd0);
    #1 compare("mr_async");
    @(posedge clk);
    #1 reset = 1'b0;
    // Busy/credits allow a strobe, so any lingering WAIT_PE would show up.
    for (int i = 0; i < 6; i++) step("mr_idle", 0, 0, 0, 0, 0, 5'b00000);
    clean_packet("mr_pkt");

    check("strobe_cnt", strobe_cnt, 6);
    check("q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
